acc_batch: RTL and testbench
============================

ACC_BATCH -- requirements
Module: acc_batch

Interface
REQ-001 Parameter GROUP_SIZE, default 4: number of parallel lanes.
REQ-002 Parameter DATA_WIDTH, default 16: signed product width per lane, matching the multiplier-batch output.
REQ-003 Parameter ACC_WIDTH, default 32: accumulator width per lane; SHALL be at least DATA_WIDTH.
REQ-004 Parameter LOG_MAX_ITERS, default 16: width of num_iters.
REQ-005 Parameter LOG_MAX_READS_PER_ITER, default 16: width of num_reads_per_iter.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 configure  input  1  one-cycle pulse that loads the configuration.
REQ-009 num_iters  input  LOG_MAX_ITERS  number of output groups to produce.
REQ-010 num_reads_per_iter  input  LOG_MAX_READS_PER_ITER  input words accumulated per output group.
REQ-011 data_in  input  GROUP_SIZE*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 valid_in  input  1  data_in valid.
REQ-013 avail_out  output  1  block accepts data_in this cycle.
REQ-014 data_out  output  GROUP_SIZE*ACC_WIDTH  lane i at bits [i*ACC_WIDTH +: ACC_WIDTH].
REQ-015 valid_out  output  1  data_out valid.
REQ-016 avail_in  input  1  downstream accepts data_out this cycle.

Function
REQ-017 Input transfer SHALL occur when valid_in && avail_out; output transfer SHALL occur when valid_out && avail_in.
REQ-018 States are IDLE, RUN and DRAIN; the block SHALL reset to IDLE.
REQ-019 configure SHALL, in any state, clear the accumulators, counters and valid_out.
REQ-020 On configure, the block SHALL latch the configuration and go to RUN; if num_iters==0 it SHALL stay in IDLE.
REQ-021 num_reads_per_iter==0 SHALL be treated as 1.
REQ-022 avail_out SHALL be 1 only when the state is RUN && !configure && (!valid_out || avail_in), so a drain and a load can happen in the same cycle.
REQ-023 Each accepted input SHALL add the sign-extended data_in lane to the lane accumulator; the sum wraps modulo 2^ACC_WIDTH.
REQ-024 Each accepted input SHALL increment read_cnt.
REQ-025 On the accepted input with read_cnt == reads-1, the block SHALL:
- load acc+data_in into the output register;
- set valid_out on the next cycle (latency 1 cycle);
- clear the accumulators and read_cnt;
- increment iter_cnt.
REQ-026 When the last read of the last iteration is accepted, the state SHALL go to DRAIN; DRAIN SHALL go to IDLE on the cycle the output transfer occurs.
REQ-027 While valid_out=1 and avail_in=0, data_out and valid_out SHALL hold stable.
REQ-028 In IDLE and DRAIN, avail_out SHALL be 0 and input SHALL be ignored.
REQ-029 valid_in=0 cycles SHALL leave all state unchanged.

Reset
REQ-030 rst low SHALL immediately force: state=IDLE, accumulators=0, counters=0, data_out=0, valid_out=0, avail_out=0.
REQ-031 After rst rises, the block SHALL stay idle until the next configure; a reset in the middle of an iteration SHALL discard partial sums.

Structure
REQ-032 The state encoding and the lane slicing helpers SHALL live in the shared package used by the multiplier-batch stages.
REQ-033 One sub-module, acc_lane (a single-lane accumulator with clear/load), SHALL be instantiated GROUP_SIZE times; the control FSM and counters stay in acc_batch.

Verification
REQ-034 Configure iters=1, reads=3; feed lanes {1,2,3,4} three times with avail_in=1 -> one output {3,6,9,12} one cycle after the 3rd accept, then IDLE.
REQ-035 Configure iters=2, reads=2; feed lane0 values -5, 3, 7, -7 (16-bit) -> outputs lane0 = -2 then 0 (ACC_WIDTH sign-extended).
REQ-036 Configure iters=2, reads=1; avail_in=0 for 5 cycles after the first output -> data_out and valid_out held and avail_out=0; when avail_in rises, the drain and the next load occur in the same cycle.
REQ-037 Configure iters=3, reads=4; assert rst low after 2 reads, then reconfigure iters=1, reads=1 with input {9,9,9,9} -> output {9,9,9,9}, no residue.
REQ-038 Configure num_iters=0 -> avail_out stays 0 and no valid_out; configure reads=0, iters=1 -> a single input passes through as the sum.
REQ-039 ACC_WIDTH=16 with lane inputs 0x7FFF twice -> lane output 0xFFFE (wrap).

Source files
------------

// File: rtl/acc_batch_pkg.sv
// Shared definitions for the batch datapath stages (multiplier batch,
// accumulator batch).
//   batch_state_t : control state encoding shared by the batch FSMs
//   lane_lsb      : LSB position of lane 'lane' in a packed multi-lane bus
//   bus_width     : total width of a packed multi-lane bus
package acc_batch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } batch_state_t;

  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned width);
    return lane * width;
  endfunction

  function automatic int unsigned bus_width(input int unsigned lanes,
                                            input int unsigned width);
    return lanes * width;
  endfunction

endpackage

// File: rtl/acc_lane.sv
// Single-lane accumulator with clear and load-out.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : zero the running sum (output register keeps its value)
//   add_en    : add sign-extended din into the running sum
//   last      : with add_en, move acc+din into dout and restart the sum at 0
//   din       : signed input word (DATA_WIDTH)
//   dout      : output register (ACC_WIDTH)
module acc_lane #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         add_en,
  input  logic                         last,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic        [ACC_WIDTH-1:0]  dout
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] din_ext;
  logic [ACC_WIDTH-1:0] sum;

  // din is signed, so the size cast sign-extends; the add wraps mod 2^ACC_WIDTH.
  assign din_ext = ACC_WIDTH'(din);
  assign sum     = acc + din_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      dout <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_en) begin
      if (last) begin
        dout <= sum;
        acc  <= '0;
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: rtl/acc_batch.sv
// Multi-lane batch accumulator. Sums num_reads_per_iter input groups per
// output group, producing num_iters output groups per configuration.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   configure           : one-cycle pulse, latches num_iters/num_reads_per_iter
//   num_iters           : output groups to produce (0 = stay idle)
//   num_reads_per_iter  : inputs summed per output group (0 treated as 1)
//   data_in/valid_in    : GROUP_SIZE signed lanes in, valid
//   avail_out           : input accepted this cycle when valid_in is high
//   data_out/valid_out  : GROUP_SIZE accumulated lanes out, valid
//   avail_in            : downstream accepts data_out this cycle
// ACC_WIDTH must be at least DATA_WIDTH.
module acc_batch
  import acc_batch_pkg::*;
#(
  parameter int unsigned GROUP_SIZE             = 4,
  parameter int unsigned DATA_WIDTH             = 16,
  parameter int unsigned ACC_WIDTH              = 32,
  parameter int unsigned LOG_MAX_ITERS          = 16,
  parameter int unsigned LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             configure,
  input  logic [LOG_MAX_ITERS-1:0]         num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
  input  logic                             valid_in,
  output logic                             avail_out,
  output logic [GROUP_SIZE*ACC_WIDTH-1:0]  data_out,
  output logic                             valid_out,
  input  logic                             avail_in
);

  localparam logic [LOG_MAX_ITERS-1:0]          ONE_I = 1;
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] ONE_R = 1;

  batch_state_t                      state;
  logic [LOG_MAX_ITERS-1:0]          iters_q;
  logic [LOG_MAX_ITERS-1:0]          iter_cnt;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_q;
  logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt;

  logic accept;
  logic out_xfer;
  logic last_read;
  logic last_iter;

  // Accepting while a full output is leaving lets a drain and a load share a cycle.
  assign avail_out = (state == ST_RUN) && !configure && (!valid_out || avail_in);
  assign accept    = valid_in && avail_out;
  assign out_xfer  = valid_out && avail_in;
  assign last_read = (read_cnt == reads_q - ONE_R);
  assign last_iter = (iter_cnt == iters_q - ONE_I);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      iters_q   <= '0;
      reads_q   <= '0;
      iter_cnt  <= '0;
      read_cnt  <= '0;
      valid_out <= 1'b0;
    end else if (configure) begin
      iters_q   <= num_iters;
      reads_q   <= (num_reads_per_iter == '0) ? ONE_R : num_reads_per_iter;
      iter_cnt  <= '0;
      read_cnt  <= '0;
      valid_out <= 1'b0;
      state     <= (num_iters == '0) ? ST_IDLE : ST_RUN;
    end else begin
      // A load in the same cycle overrides the transfer's clear below.
      if (out_xfer) begin
        valid_out <= 1'b0;
      end
      if (accept) begin
        if (last_read) begin
          read_cnt  <= '0;
          iter_cnt  <= iter_cnt + ONE_I;
          valid_out <= 1'b1;
          if (last_iter) begin
            state <= ST_DRAIN;
          end
        end else begin
          read_cnt <= read_cnt + ONE_R;
        end
      end
      if ((state == ST_DRAIN) && out_xfer) begin
        state <= ST_IDLE;
      end
    end
  end

  for (genvar i = 0; i < GROUP_SIZE; i++) begin : g_lane
    acc_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clear (configure),
      .add_en(accept),
      .last  (last_read),
      .din   (data_in[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .dout  (data_out[lane_lsb(i, ACC_WIDTH) +: ACC_WIDTH])
    );
  end

endmodule

// File: tb/tb_acc_batch.sv
module tb_acc_batch;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         configure = 1'b0;
  logic [15:0]  num_iters = '0;
  logic [15:0]  num_reads = '0;
  logic [63:0]  data_in = '0;
  logic         valid_in = 1'b0;
  logic         avail_in = 1'b1;
  logic         avail_out, valid_out;
  logic [127:0] data_out;
  logic         avail_out16, valid_out16;
  logic [63:0]  data_out16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  acc_batch #(
    .GROUP_SIZE(4), .DATA_WIDTH(16), .ACC_WIDTH(32),
    .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16)
  ) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads), .data_in(data_in), .valid_in(valid_in),
    .avail_out(avail_out), .data_out(data_out), .valid_out(valid_out),
    .avail_in(avail_in)
  );

  acc_batch #(
    .GROUP_SIZE(4), .DATA_WIDTH(16), .ACC_WIDTH(16),
    .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16)
  ) dut16 (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads), .data_in(data_in), .valid_in(valid_in),
    .avail_out(avail_out16), .data_out(data_out16), .valid_out(valid_out16),
    .avail_in(avail_in)
  );

  typedef struct packed {
    logic [15:0]        reads;
    logic [3:0][63:0]   w;
    logic [127:0]       exp;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [63:0] pk16(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [127:0] pk32(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int iters, input int reads);
    configure = 1'b1;
    num_iters = 16'(iters);
    num_reads = 16'(reads);
    valid_in  = 1'b0;
    tick;
    configure = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0].reads = 16'd3;
    vecs[0].w[0] = pk16(1, 2, 3, 4);
    vecs[0].w[1] = pk16(1, 2, 3, 4);
    vecs[0].w[2] = pk16(1, 2, 3, 4);
    vecs[0].w[3] = '0;
    vecs[0].exp  = pk32(3, 6, 9, 12);

    vecs[1].reads = 16'd0;
    vecs[1].w[0] = pk16(10, -20, 30, -40);
    vecs[1].w[1] = '0;
    vecs[1].w[2] = '0;
    vecs[1].w[3] = '0;
    vecs[1].exp  = pk32(10, -20, 30, -40);

    vecs[2].reads = 16'd1;
    vecs[2].w[0] = pk16(-1, 32767, -32768, 5);
    vecs[2].w[1] = '0;
    vecs[2].w[2] = '0;
    vecs[2].w[3] = '0;
    vecs[2].exp  = pk32(-1, 32767, -32768, 5);

    vecs[3].reads = 16'd2;
    vecs[3].w[0] = pk16(-32768, 100, -3, 0);
    vecs[3].w[1] = pk16(-32768, -100, -4, 7);
    vecs[3].w[2] = '0;
    vecs[3].w[3] = '0;
    vecs[3].exp  = pk32(-65536, 0, -7, 7);

    vecs[4].reads = 16'd4;
    vecs[4].w[0] = pk16(1, 1, 1, 1);
    vecs[4].w[1] = pk16(2, 2, 2, 2);
    vecs[4].w[2] = pk16(3, 3, 3, 3);
    vecs[4].w[3] = pk16(4, 4, 4, 4);
    vecs[4].exp  = pk32(10, 10, 10, 10);

    // Reset state
    #12;
    check("rst avail_out", avail_out, 0);
    check("rst valid_out", valid_out, 0);
    check("rst data_out", data_out, 0);
    check("rst data_out16", data_out16, 0);
    tick;
    rst = 1'b1;
    valid_in = 1'b1;
    #1;
    check("idle after rst avail_out", avail_out, 0);
    tick;
    valid_in = 1'b0;

    // Single-iteration table: sums, sign extension, reads==0 as 1
    for (int v = 0; v < 5; v++) begin
      int n;
      n = (vecs[v].reads == 16'd0) ? 1 : int'(vecs[v].reads);
      cfg(1, int'(vecs[v].reads));
      avail_in = 1'b1;
      for (int k = 0; k < n; k++) begin
        valid_in = 1'b1;
        data_in  = vecs[v].w[k];
        #1;
        check($sformatf("v%0d avail_out read%0d", v, k), avail_out, 1);
        check($sformatf("v%0d valid_out early read%0d", v, k), valid_out, 0);
        tick;
      end
      valid_in = 1'b0;
      data_in  = '0;
      check($sformatf("v%0d valid_out", v), valid_out, 1);
      check($sformatf("v%0d data_out", v), data_out, vecs[v].exp);
      tick;
      check($sformatf("v%0d valid_out after xfer", v), valid_out, 0);
      check($sformatf("v%0d avail_out idle", v), avail_out, 0);
    end

    // Two iterations of two reads with signed values
    cfg(2, 2);
    avail_in = 1'b1;
    valid_in = 1'b1;
    data_in  = pk16(-5, 0, 0, 0);
    tick;
    data_in  = pk16(3, 0, 0, 0);
    tick;
    check("neg it0 valid_out", valid_out, 1);
    check("neg it0 data_out", data_out, pk32(-2, 0, 0, 0));
    data_in  = pk16(7, 0, 0, 0);
    #1;
    check("neg it1 avail_out", avail_out, 1);
    tick;
    check("neg mid valid_out", valid_out, 0);
    data_in  = pk16(-7, 0, 0, 0);
    tick;
    check("neg it1 valid_out", valid_out, 1);
    check("neg it1 data_out", data_out, pk32(0, 0, 0, 0));
    #1;
    check("neg drain avail_out", avail_out, 0);
    tick;
    check("neg drained valid_out", valid_out, 0);
    valid_in = 1'b0;

    // Backpressure: hold for 5 cycles, then drain and load together
    cfg(2, 1);
    avail_in = 1'b0;
    valid_in = 1'b1;
    data_in  = pk16(1, 2, 3, 4);
    #1;
    check("bp first avail_out", avail_out, 1);
    tick;
    check("bp first valid_out", valid_out, 1);
    check("bp first data_out", data_out, pk32(1, 2, 3, 4));
    data_in = pk16(5, 6, 7, 8);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp hold%0d avail_out", i), avail_out, 0);
      tick;
      check($sformatf("bp hold%0d valid_out", i), valid_out, 1);
      check($sformatf("bp hold%0d data_out", i), data_out, pk32(1, 2, 3, 4));
    end
    avail_in = 1'b1;
    #1;
    check("bp release avail_out", avail_out, 1);
    tick;
    check("bp second valid_out", valid_out, 1);
    check("bp second data_out", data_out, pk32(5, 6, 7, 8));
    valid_in = 1'b0;
    #1;
    check("bp drain avail_out", avail_out, 0);
    tick;
    check("bp drained valid_out", valid_out, 0);

    // Reset mid-iteration discards partial sums and clears data_out
    cfg(3, 4);
    valid_in = 1'b1;
    data_in  = pk16(100, 200, 300, 400);
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("midrst data_out", data_out, 0);
    check("midrst valid_out", valid_out, 0);
    check("midrst avail_out", avail_out, 0);
    tick;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("post rst idle%0d avail_out", i), avail_out, 0);
      tick;
    end
    cfg(1, 1);
    valid_in = 1'b1;
    data_in  = pk16(9, 9, 9, 9);
    tick;
    valid_in = 1'b0;
    check("reconf valid_out", valid_out, 1);
    check("reconf data_out", data_out, pk32(9, 9, 9, 9));
    tick;
    check("reconf drained valid_out", valid_out, 0);

    // num_iters == 0 stays idle
    cfg(0, 5);
    valid_in = 1'b1;
    data_in  = pk16(1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("zero iters avail_out%0d", i), avail_out, 0);
      tick;
      check($sformatf("zero iters valid_out%0d", i), valid_out, 0);
    end
    valid_in = 1'b0;

    // configure while an output is pending clears valid_out and restarts
    cfg(2, 1);
    avail_in = 1'b0;
    valid_in = 1'b1;
    data_in  = pk16(11, 12, 13, 14);
    tick;
    check("reconf pend valid_out", valid_out, 1);
    configure = 1'b1;
    num_iters = 16'd2;
    num_reads = 16'd1;
    #1;
    check("configure gates avail_out", avail_out, 0);
    tick;
    configure = 1'b0;
    check("configure clears valid_out", valid_out, 0);
    avail_in = 1'b1;
    data_in  = pk16(-1, -2, -3, -4);
    tick;
    check("restart valid_out", valid_out, 1);
    check("restart data_out", data_out, pk32(-1, -2, -3, -4));
    #1;
    check("restart still run avail_out", avail_out, 1);
    valid_in = 1'b0;
    tick;
    check("restart xfer valid_out", valid_out, 0);
    cfg(0, 0);

    // Wrap: 16-bit accumulator vs 32-bit accumulator
    cfg(1, 2);
    avail_in = 1'b1;
    valid_in = 1'b1;
    data_in  = pk16('h7FFF, 1, -1, -32768);
    tick;
    tick;
    valid_in = 1'b0;
    check("wrap16 valid_out", valid_out16, 1);
    check("wrap16 data_out", data_out16, pk16('hFFFE, 2, -2, 0));
    check("wrap32 data_out", data_out, pk32('hFFFE, 2, -2, -65536));
    tick;
    check("wrap16 drained valid_out", valid_out16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
